// File: rtl/onehot_or_tree.sv
// Combinational one-hot to binary encoder: each index bit is a flat OR of the
// input bits whose position has that index bit set, so there is no priority chain.
module onehot_or_tree #(
    parameter int INPUT_W  = 3,
    parameter int OUTPUT_W = 2
) (
    input  logic [INPUT_W-1:0]  i,
    output logic [OUTPUT_W-1:0] enc
);
    localparam int IDX_W = $clog2(INPUT_W);

    always_comb begin
        enc = '0;
        for (int b = 0; b < IDX_W; b++) begin
            for (int k = 0; k < INPUT_W; k++) begin
                if (((k >> b) % 2) == 1) begin
                    enc[b] = enc[b] | i[k];
                end
            end
        end
    end
endmodule

// File: rtl/onehot_encoder.sv
// Registered one-hot encoder with exactly-one (valid) and zero/multi-hot (error)
// flags; the flags come from a log-depth any/multi reduction tree.
module onehot_encoder #(
    parameter int INPUT_W  = 3,
    parameter int OUTPUT_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INPUT_W-1:0]  i,
    output logic [OUTPUT_W-1:0] o,
    output logic                o_vld,
    output logic                o_err
);
    localparam int IDX_W = $clog2(INPUT_W);
    localparam int PAD_W = 1 << IDX_W;

    if (INPUT_W < 2 || INPUT_W > 1024) begin : g_bad_input_w
        $error("onehot_encoder: INPUT_W must be in 2..1024");
    end
    if (OUTPUT_W < IDX_W) begin : g_bad_output_w
        $error("onehot_encoder: OUTPUT_W smaller than clog2(INPUT_W)");
    end

    logic [OUTPUT_W-1:0] enc;
    logic [PAD_W-1:0]    any_v;
    logic [PAD_W-1:0]    mul_v;
    logic                one_hot;

    logic [OUTPUT_W-1:0] o_d, o_q;
    logic                vld_d, vld_q;
    logic                err_d, err_q;

    onehot_or_tree #(
        .INPUT_W  (INPUT_W),
        .OUTPUT_W (OUTPUT_W)
    ) u_or_tree (
        .i   (i),
        .enc (enc)
    );

    // Pairwise tree folded in place: node j of a level is built from nodes
    // 2j and 2j+1 of the level below; mul is updated before any so it sees
    // the children, not the freshly written parent.
    always_comb begin
        any_v = '0;
        mul_v = '0;
        any_v[INPUT_W-1:0] = i;
        for (int lvl = 0; lvl < IDX_W; lvl++) begin
            for (int j = 0; j < (PAD_W >> (lvl + 1)); j++) begin
                mul_v[j] = mul_v[2*j] | mul_v[2*j+1] | (any_v[2*j] & any_v[2*j+1]);
                any_v[j] = any_v[2*j] | any_v[2*j+1];
            end
        end
        one_hot = any_v[0] & ~mul_v[0];
    end

    always_comb begin
        o_d   = enc;
        vld_d = one_hot;
        err_d = ~one_hot;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_q   <= '0;
            vld_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            o_q   <= o_d;
            vld_q <= vld_d;
            err_q <= err_d;
        end
    end

    assign o     = o_q;
    assign o_vld = vld_q;
    assign o_err = err_q;
endmodule

// File: tb/tb_onehot_encoder.sv
// Directed bench for onehot_encoder in the default, 16-bit and 5-bit configurations.
module tb_onehot_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [2:0]  i3 = '0;
    logic [1:0]  o3;
    logic        vld3, err3;

    logic [15:0] i16 = '0;
    logic [3:0]  o16;
    logic        vld16, err16;

    logic [4:0]  i5 = '0;
    logic [3:0]  o5;
    logic        vld5, err5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    onehot_encoder #(.INPUT_W(3), .OUTPUT_W(2)) dut3 (
        .clk(clk), .rst(rst), .i(i3), .o(o3), .o_vld(vld3), .o_err(err3)
    );
    onehot_encoder #(.INPUT_W(16), .OUTPUT_W(4)) dut16 (
        .clk(clk), .rst(rst), .i(i16), .o(o16), .o_vld(vld16), .o_err(err16)
    );
    onehot_encoder #(.INPUT_W(5), .OUTPUT_W(4)) dut5 (
        .clk(clk), .rst(rst), .i(i5), .o(o5), .o_vld(vld5), .o_err(err5)
    );

    // {o, o_vld, o_err} packed for compact comparison
    task automatic test_reset();
        rst = 1'b1;
        i3  = 3'b100;
        i16 = 16'h8000;
        i5  = 5'b10000;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            total++;
            if ({o3, vld3, err3} !== 4'b0000) begin
                bad++;
                $display("FAIL reset3 cyc%0d got o=%0d vld=%0b err=%0b want 0 0 0", c, o3, vld3, err3);
            end
            total++;
            if ({o16, vld16, err16, o5, vld5, err5} !== 12'h000) begin
                bad++;
                $display("FAIL reset_wide cyc%0d got o16=%0d v=%0b e=%0b o5=%0d v=%0b e=%0b want all 0",
                         c, o16, vld16, err16, o5, vld5, err5);
            end
        end
    endtask

    task automatic test_walk();
        logic [2:0] vin [3] = '{3'b001, 3'b010, 3'b100};
        logic [3:0] exp [3] = '{4'b00_10, 4'b01_10, 4'b10_10};
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            i3 = vin[n];
            @(posedge clk); #1;
            total++;
            if ({o3, vld3, err3} !== exp[n]) begin
                bad++;
                $display("FAIL walk i=%b got {o,vld,err}=%b want %b", vin[n], {o3, vld3, err3}, exp[n]);
            end
        end
    endtask

    task automatic test_zero();
        i3 = 3'b000;
        @(posedge clk); #1;
        total++;
        if ({o3, vld3, err3} !== 4'b00_01) begin
            bad++;
            $display("FAIL zero got {o,vld,err}=%b want 0001", {o3, vld3, err3});
        end
    endtask

    task automatic test_multi();
        logic [2:0] vin [3] = '{3'b011, 3'b110, 3'b111};
        logic [3:0] exp [3] = '{4'b01_01, 4'b11_01, 4'b11_01};
        for (int n = 0; n < 3; n++) begin
            i3 = vin[n];
            @(posedge clk); #1;
            total++;
            if ({o3, vld3, err3} !== exp[n]) begin
                bad++;
                $display("FAIL multi i=%b got {o,vld,err}=%b want %b", vin[n], {o3, vld3, err3}, exp[n]);
            end
        end
    endtask

    task automatic test_wide();
        logic [15:0] v16 [3] = '{16'h8000, 16'h0000, 16'h8001};
        logic [5:0]  e16 [3] = '{6'b1111_10, 6'b0000_01, 6'b1111_01};
        logic [4:0]  v5  [3] = '{5'b10000, 5'b00100, 5'b10100};
        logic [5:0]  e5  [3] = '{6'b0100_10, 6'b0010_10, 6'b0110_01};
        for (int n = 0; n < 3; n++) begin
            i16 = v16[n];
            i5  = v5[n];
            @(posedge clk); #1;
            total++;
            if ({o16, vld16, err16} !== e16[n]) begin
                bad++;
                $display("FAIL wide16 i=%h got {o,vld,err}=%b want %b", v16[n], {o16, vld16, err16}, e16[n]);
            end
            total++;
            if ({o5, vld5, err5} !== e5[n]) begin
                bad++;
                $display("FAIL wide5 i=%b got {o,vld,err}=%b want %b", v5[n], {o5, vld5, err5}, e5[n]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] vin [6] = '{3'b100, 3'b000, 3'b001, 3'b101, 3'b010, 3'b100};
        logic [3:0] exp [6] = '{4'b10_10, 4'b00_01, 4'b00_10, 4'b10_01, 4'b01_10, 4'b10_10};
        for (int n = 0; n < 6; n++) begin
            i3 = vin[n];
            @(posedge clk); #1;
            total++;
            if ({o3, vld3, err3} !== exp[n]) begin
                bad++;
                $display("FAIL b2b step%0d i=%b got {o,vld,err}=%b want %b", n, vin[n], {o3, vld3, err3}, exp[n]);
            end
            total++;
            if (vld3 === err3) begin
                bad++;
                $display("FAIL excl step%0d got vld=%b err=%b want opposite values", n, vld3, err3);
            end
        end
    endtask

    task automatic test_mid_reset();
        i3 = 3'b001;
        @(posedge clk); #1;
        total++;
        if ({o3, vld3, err3} !== 4'b00_10) begin
            bad++;
            $display("FAIL midrst_pre got {o,vld,err}=%b want 0010", {o3, vld3, err3});
        end
        i3  = 3'b010;
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({o3, vld3, err3} !== 4'b00_00) begin
            bad++;
            $display("FAIL midrst_hold got {o,vld,err}=%b want 0000", {o3, vld3, err3});
        end
        rst = 1'b0;
        i3  = 3'b100;
        @(posedge clk); #1;
        total++;
        if ({o3, vld3, err3} !== 4'b10_10) begin
            bad++;
            $display("FAIL midrst_resume got {o,vld,err}=%b want 1010", {o3, vld3, err3});
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_walk();
        test_zero();
        test_multi();
        test_wide();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
